// File: rtl/npc_gen.sv
// -----------------------------------------------------------------------------
// npc_gen -- next-PC generator
//
// Owns the architectural fetch PC and presents it to IF0. A redirect from the
// redirect arbiter always wins, is never back-pressured, bumps the epoch tag
// and raises a one-cycle flush. Otherwise the PC advances to the next aligned
// fetch block on every IF0 handshake (valid & ready), or holds on a stall.
// After reset the block spends one BOOT cycle with valid low, then stays in
// RUN with valid high until the next reset.
//
// Configuration macros:
//   MXLEN               PC width (defaults to 64 when not defined elsewhere)
//   NPCGEN_PERF_CNT_EN  adds saturating 32-bit redirect / stall counters
//
// Ports:
//   i_clk                               in   clock
//   i_rst_n                             in   synchronous active-low reset
//   i_pcRedirect_npcGen_npc             in   redirect target PC
//   i_pcRedirect_npcGen_redirect_valid  in   redirect request (one cycle)
//   i_if0_npcGen_ready                  in   IF0 accepts presented PC
//   o_npcGen_if0_pc                     out  PC presented to IF0
//   o_npcGen_if0_valid                  out  PC valid
//   o_npcGen_if0_epoch                  out  epoch tag of presented PC
//   o_npcGen_flush                      out  one-cycle stale-fetch flush
//   o_npcGen_perf_redirect_cnt          out  redirect count (perf build only)
//   o_npcGen_perf_stall_cnt             out  stall count (perf build only)
// -----------------------------------------------------------------------------
`ifndef MXLEN
`define MXLEN 64
`endif

module npc_gen #(
  parameter int                 FETCH_BYTES = 16,
  parameter logic [`MXLEN-1:0]  RESET_PC    = {{(`MXLEN-32){1'b0}}, 32'h8000_0000},
  parameter int                 EPOCH_W     = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [`MXLEN-1:0]  i_pcRedirect_npcGen_npc,
  input  logic               i_pcRedirect_npcGen_redirect_valid,
  input  logic               i_if0_npcGen_ready,
  output logic [`MXLEN-1:0]  o_npcGen_if0_pc,
  output logic               o_npcGen_if0_valid,
  output logic [EPOCH_W-1:0] o_npcGen_if0_epoch,
`ifdef NPCGEN_PERF_CNT_EN
  output logic [31:0]        o_npcGen_perf_redirect_cnt,
  output logic [31:0]        o_npcGen_perf_stall_cnt,
`endif
  output logic               o_npcGen_flush
);

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [`MXLEN-1:0]  BLK_MASK  = `MXLEN'(FETCH_BYTES - 1);
  localparam logic [`MXLEN-1:0]  BLK_INC   = `MXLEN'(FETCH_BYTES);
  localparam logic [`MXLEN-1:0]  HALF_MASK = `MXLEN'(1);
  localparam logic [EPOCH_W-1:0] EPOCH_ONE = EPOCH_W'(1);

  state_t               state_r, stateNext_s;
  logic [`MXLEN-1:0]    pc_r, pcNext_s;
  logic                 valid_r, validNext_s;
  logic [EPOCH_W-1:0]   epoch_r, epochNext_s;
  logic                 flush_r, flushNext_s;

  // Next-state and next-output selection: redirect > handshake advance > hold.
  always_comb begin
    stateNext_s = state_r;
    pcNext_s    = pc_r;
    validNext_s = valid_r;
    epochNext_s = epoch_r;
    flushNext_s = 1'b0;
    if (i_pcRedirect_npcGen_redirect_valid) begin
      // Bit 0 is cleared: fetch targets are at least halfword aligned.
      pcNext_s    = i_pcRedirect_npcGen_npc & ~HALF_MASK;
      epochNext_s = epoch_r + EPOCH_ONE;
      flushNext_s = 1'b1;
      stateNext_s = RUN;
      validNext_s = 1'b1;
    end else begin
      case (state_r)
        BOOT: begin
          stateNext_s = RUN;
          validNext_s = 1'b1;
        end
        RUN: begin
          validNext_s = 1'b1;
          if (valid_r && i_if0_npcGen_ready) begin
            // Re-align first so a mid-block redirect target resumes on a block boundary.
            pcNext_s = (pc_r & ~BLK_MASK) + BLK_INC;
          end else begin
            pcNext_s = pc_r;
          end
        end
        default: begin
          stateNext_s = BOOT;
          validNext_s = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r <= BOOT;
      pc_r    <= RESET_PC;
      valid_r <= 1'b0;
      epoch_r <= '0;
      flush_r <= 1'b0;
    end else begin
      state_r <= stateNext_s;
      pc_r    <= pcNext_s;
      valid_r <= validNext_s;
      epoch_r <= epochNext_s;
      flush_r <= flushNext_s;
    end
  end

  assign o_npcGen_if0_pc    = pc_r;
  assign o_npcGen_if0_valid = valid_r;
  assign o_npcGen_if0_epoch = epoch_r;
  assign o_npcGen_flush     = flush_r;

`ifdef NPCGEN_PERF_CNT_EN
  logic [31:0] redirCnt_r;
  logic [31:0] stallCnt_r;
  logic        stallEvt_s;

  assign stallEvt_s = (state_r == RUN) && valid_r && !i_if0_npcGen_ready &&
                      !i_pcRedirect_npcGen_redirect_valid;

  // Saturating performance counters for redirects and IF0 stall cycles.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      redirCnt_r <= 32'd0;
      stallCnt_r <= 32'd0;
    end else begin
      if (i_pcRedirect_npcGen_redirect_valid && (redirCnt_r != 32'hFFFF_FFFF)) begin
        redirCnt_r <= redirCnt_r + 32'd1;
      end else begin
        redirCnt_r <= redirCnt_r;
      end
      if (stallEvt_s && (stallCnt_r != 32'hFFFF_FFFF)) begin
        stallCnt_r <= stallCnt_r + 32'd1;
      end else begin
        stallCnt_r <= stallCnt_r;
      end
    end
  end

  assign o_npcGen_perf_redirect_cnt = redirCnt_r;
  assign o_npcGen_perf_stall_cnt    = stallCnt_r;
`endif

endmodule
